sa_c_drain: RTL and testbench

- Output-side collector for the systolic array: the consumer of the array's `c_dout`/`out_valid` end of the SA interface.
- The array drains C one row per cycle over N consecutive cycles; `out_valid` marks the cycle carrying the final row.
- The block snapshots the complete N-row matrix, buffers it, and streams it row by row on a valid/ready master port to downstream logic (writeback/DMA).
- Width reduction is applied on the output path.

---
 rtl/sa_c_drain.sv | 151 +++++++++++++++
 tb/tb_sa_c_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_c_drain.sv
// rtl/sa_c_drain.sv - systolic array C-drain collector: N-row snapshot, two-bank buffer, row streamer
// Optional SA_DRAIN_SAT_EN: signed-saturate output elements instead of truncating them.
module sa_c_drain #(
    parameter int DIN_WIDTH  = 8,
    parameter int N          = 4,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*2*DIN_WIDTH-1:0]    c_dout,
    input  logic                        out_valid,
    output logic [N*DOUT_WIDTH-1:0]     m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic [$clog2(N)-1:0]        m_row,
    output logic                        busy,
    output logic                        overflow
);

    localparam int CW  = 2 * DIN_WIDTH;
    localparam int RW  = $clog2(N);
    localparam int ROW = N * CW;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    if (DOUT_WIDTH > CW) begin : g_width_err
        $error("sa_c_drain: DOUT_WIDTH must not exceed 2*DIN_WIDTH");
    end
    if (N < 2) begin : g_n_err
        $error("sa_c_drain: N must be at least 2");
    end

    logic [ROW-1:0] hist_q   [N-1];
    logic [ROW-1:0] snap     [N];
    logic [ROW-1:0] active_q [N];
    logic [ROW-1:0] active_d [N];
    logic [ROW-1:0] pend_q   [N];
    logic [ROW-1:0] pend_d   [N];
    logic           pend_full_q, pend_full_d;
    logic [0:0]     state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic           ovf_q, ovf_d;
    logic           beat, last_beat;
    logic [ROW-1:0] act_row;

    // hist_q[k] holds c_dout from k+1 cycles ago; the oldest entry becomes row 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N - 1; k++) hist_q[k] <= '0;
        end else begin
            hist_q[0] <= c_dout;
            for (int k = 1; k < N - 1; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    always_comb begin
        for (int r = 0; r < N - 1; r++) snap[r] = hist_q[N-2-r];
        snap[N-1] = c_dout;
    end

    assign beat      = (state_q == S_STREAM) && m_ready;
    assign last_beat = beat && (row_q == RW'(N - 1));

    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        state_d     = state_q;
        row_d       = row_q;
        ovf_d       = ovf_q;

        if (beat && !last_beat) row_d = row_q + RW'(1);

        if (last_beat) begin
            row_d = '0;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end

        // A bank freed on this same cycle can accept the new snapshot
        if (out_valid) begin
            if ((state_q == S_IDLE) || (last_beat && !pend_full_q)) begin
                active_d = snap;
                row_d    = '0;
                state_d  = S_STREAM;
            end else if (!pend_full_q || last_beat) begin
                pend_d      = snap;
                pend_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                active_q[r] <= '0;
                pend_q[r]   <= '0;
            end
            pend_full_q <= 1'b0;
            state_q     <= S_IDLE;
            row_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            state_q     <= state_d;
            row_q       <= row_d;
            ovf_q       <= ovf_d;
        end
    end

    assign act_row  = active_q[row_q];
    assign m_valid  = (state_q == S_STREAM);
    assign m_last   = m_valid && (row_q == RW'(N - 1));
    assign m_row    = row_q;
    assign busy     = m_valid || pend_full_q;
    assign overflow = ovf_q;

`ifdef SA_DRAIN_SAT_EN
    localparam logic [DOUT_WIDTH-1:0] DMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] DMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
`endif

    for (genvar e = 0; e < N; e++) begin : g_el
        logic [CW-1:0] v;
        assign v = act_row[e*CW +: CW];
        if (DOUT_WIDTH >= CW) begin : g_pass
            assign m_data[e*DOUT_WIDTH +: DOUT_WIDTH] = DOUT_WIDTH'(v);
        end else begin : g_narrow
`ifdef SA_DRAIN_SAT_EN
            // Value fits when every bit above the target sign bit equals the sign
            logic fits;
            assign fits = (v[CW-1:DOUT_WIDTH-1] == {(CW-DOUT_WIDTH+1){v[CW-1]}});
            assign m_data[e*DOUT_WIDTH +: DOUT_WIDTH] =
                fits ? DOUT_WIDTH'(v) : (v[CW-1] ? DMIN : DMAX);
`else
            assign m_data[e*DOUT_WIDTH +: DOUT_WIDTH] = DOUT_WIDTH'(v);
`endif
        end
    end

endmodule

// File: tb/tb_sa_c_drain.sv
// tb/tb_sa_c_drain.sv - scoreboard bench for sa_c_drain (16-bit and 12-bit output instances)
module tb_sa_c_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] c_dout;
    logic        out_valid;
    logic        m_ready;

    logic [63:0] m_data;
    logic        m_valid, m_last, busy, overflow;
    logic [1:0]  m_row;

    logic [47:0] m_data12;
    logic        m_valid12, m_last12, busy12, overflow12;
    logic [1:0]  m_row12;

    always #5 clk = ~clk;

    sa_c_drain #(.DIN_WIDTH(8), .N(4), .DOUT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .c_dout(c_dout), .out_valid(out_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_row(m_row), .busy(busy), .overflow(overflow)
    );

    sa_c_drain #(.DIN_WIDTH(8), .N(4), .DOUT_WIDTH(12)) u_dut12 (
        .clk(clk), .rst(rst), .c_dout(c_dout), .out_valid(out_valid),
        .m_data(m_data12), .m_valid(m_valid12), .m_ready(m_ready), .m_last(m_last12),
        .m_row(m_row12), .busy(busy12), .overflow(overflow12)
    );

    typedef struct {
        logic [63:0] row;
        int          idx;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] h[3];
    bit          keep_ov = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] conv(input logic [63:0] row, input int w);
        logic [63:0] r;
        r = '0;
        for (int e = 0; e < 4; e++) begin
            int          v;
            logic [15:0] o;
            v = $signed(row[e*16 +: 16]);
            if (w == 16) begin
                o = row[e*16 +: 16];
            end else begin
`ifdef SA_DRAIN_SAT_EN
                if (v > 2047) v = 2047;
                else if (v < -2048) v = -2048;
`endif
                o = 16'(v) & 16'h0FFF;
            end
            r = r | (64'(o) << (e * w));
        end
        return r;
    endfunction

    function automatic logic [63:0] mkrow(input int k);
        return {16'h0300 | 16'(k), 16'h0200 | 16'(k), 16'h0100 | 16'(k), 16'(k)};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic step(input logic [63:0] d, input bit ov);
        c_dout    = d;
        out_valid = ov;
        if (ov && !rst && keep_ov) begin
            sb_q.push_back('{h[2], 0});
            sb_q.push_back('{h[1], 1});
            sb_q.push_back('{h[0], 2});
            sb_q.push_back('{d, 3});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 3; i++) h[i] = '0;
        end else begin
            h[2] = h[1];
            h[1] = h[0];
            h[0] = d;
        end
        out_valid = 1'b0;
    endtask

    task automatic load_matrix();
        repeat (3) step(rnd64(), 1'b0);
        step(rnd64(), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        step(rnd64(), 1'b0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && m_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 64'(m_valid), 64'd0);
            end else begin
                chk("m_data", m_data, conv(sb_q[0].row, 16));
                chk("m_data12", {16'h0, m_data12}, conv(sb_q[0].row, 12));
                chk("m_row", 64'(m_row), 64'(sb_q[0].idx));
                chk("m_last", 64'(m_last), 64'(sb_q[0].idx == 3));
                if (m_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] sat_row;
        logic [47:0] sat_exp;
        rst = 1'b1; out_valid = 1'b0; m_ready = 1'b1; c_dout = '0;
        for (int i = 0; i < 3; i++) h[i] = '0;
        step('0, 1'b0);
        step('0, 1'b0);
        rst = 1'b0;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_row", 64'(m_row), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // basic drain, latency 1 from out_valid
        step(mkrow(1), 1'b0);
        step(mkrow(2), 1'b0);
        step(mkrow(3), 1'b0);
        chk("basic_pre_valid", 64'(m_valid), 64'd0);
        step(mkrow(4), 1'b1);
        chk("basic_lat1_valid", 64'(m_valid), 64'd1);
        chk("basic_row0_data", m_data, mkrow(1));
        chk("basic_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(rnd64(), 1'b0);
            chk("basic_valid_run", 64'(m_valid), 64'd1);
        end
        chk("basic_last", 64'(m_last), 64'd1);
        step(rnd64(), 1'b0);
        chk("basic_idle_valid", 64'(m_valid), 64'd0);
        chk("basic_drained", 64'(sb_q.size()), 64'd0);

        // backpressure at row 1
        load_matrix();
        step(rnd64(), 1'b0);
        m_ready = 1'b0;
        repeat (5) step(rnd64(), 1'b0);
        chk("bp_row_held", 64'(m_row), 64'd1);
        m_ready = 1'b1;
        repeat (3) step(rnd64(), 1'b0);
        chk("bp_idle_valid", 64'(m_valid), 64'd0);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);
        chk("bp_overflow", 64'(overflow), 64'd0);

        // back-to-back: second out_valid on the first matrix's last beat
        load_matrix();
        chk("b2b_valid", 64'(m_valid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            step(rnd64(), i == 3);
            chk("b2b_no_bubble", 64'(m_valid), 64'd1);
        end
        step(rnd64(), 1'b0);
        chk("b2b_idle_valid", 64'(m_valid), 64'd0);
        chk("b2b_drained", 64'(sb_q.size()), 64'd0);

        // overflow: third matrix dropped while stalled
        m_ready = 1'b0;
        load_matrix();
        load_matrix();
        chk("ovf_not_yet", 64'(overflow), 64'd0);
        keep_ov = 1'b0;
        load_matrix();
        keep_ov = 1'b1;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_busy", 64'(busy), 64'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(rnd64(), 1'b0);
            chk("ovf_drain_valid", 64'(m_valid), 64'd1);
        end
        step(rnd64(), 1'b0);
        chk("ovf_idle_valid", 64'(m_valid), 64'd0);
        chk("ovf_drained", 64'(sb_q.size()), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_busy_clear", 64'(busy), 64'd0);

        // width conversion on the 12-bit instance
        sat_row = {16'h8000, 16'h7FFF, 16'hF000, 16'h0900};
`ifdef SA_DRAIN_SAT_EN
        sat_exp = 48'h800_7FF_800_7FF;
`else
        sat_exp = 48'h000_FFF_000_900;
`endif
        repeat (3) step(sat_row, 1'b0);
        step(sat_row, 1'b1);
        chk("sat_data16", m_data, sat_row);
        chk("sat_data12", {16'h0, m_data12}, {16'h0, sat_exp});
        repeat (4) step(rnd64(), 1'b0);
        chk("sat_drained", 64'(sb_q.size()), 64'd0);

        // reset mid-stream, overflow still set from above
        load_matrix();
        step(rnd64(), 1'b0);
        step(rnd64(), 1'b0);
        chk("rms_row2", 64'(m_row), 64'd2);
        do_reset();
        chk("rms_valid", 64'(m_valid), 64'd0);
        chk("rms_row", 64'(m_row), 64'd0);
        chk("rms_overflow", 64'(overflow), 64'd0);
        chk("rms_busy", 64'(busy), 64'd0);
        step(mkrow(7), 1'b0);
        step(mkrow(8), 1'b1);
        chk("rms_row0_zero", m_data, 64'd0);
        repeat (4) step(rnd64(), 1'b0);
        chk("rms_idle_valid", 64'(m_valid), 64'd0);
        chk("rms_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
